// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Brief    : Shared types and helpers for the bit-serial adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width: must be able to hold the value WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_bit_slice.sv
//------------------------------------------------------------------------------
// Module   : serial_bit_slice
// Brief    : One full-adder slice plus the carry flip-flop of the serial adder.
//            Optional macro SERIAL_ADDER_OVERFLOW_EN exposes the current carry
//            (carry into the bit being processed) for overflow detection.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_bit_slice (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic carry_init,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry_nxt
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic carry
`endif
);

    logic r_c;

    assign s         = a ^ b ^ r_c;
    assign carry_nxt = (a & b) | (a & r_c) | (b & r_c);

`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign carry = r_c;
`endif

    // Carry flop: loaded with the initial carry on start, then ripples one bit per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c <= 1'b0;
        end else if (load) begin
            r_c <= carry_init;
        end else if (en) begin
            r_c <= carry_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, LSB first, one bit per cycle, with a
//            start/busy/done handshake. {carryout,sum} = a + b + carryin.
//            Optional macro SERIAL_ADDER_OVERFLOW_EN adds a registered signed
//            overflow output updated together with sum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_s;
    logic             w_c_nxt;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             w_c;
`endif

    // start is only honoured when no add is in flight (IDLE or DONE)
    assign w_accept = start && (r_state != ST_RUN);
    assign w_step   = (r_state == ST_RUN);
    assign w_last   = w_step && (r_cnt == CW'(WIDTH - 1));

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

    serial_bit_slice u_slice (
        .clk        (clk),
        .reset      (reset),
        .load       (w_accept),
        .carry_init (carryin),
        .en         (w_step),
        .a          (r_a_sh[0]),
        .b          (r_b_sh[0]),
        .s          (w_s),
        .carry_nxt  (w_c_nxt)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .carry      (w_c)
`endif
    );

    // Partial result: new sum bit enters at the MSB and the word shifts right.
    // Only WIDTH-1 bits need storage; the final bit goes straight to sum.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_s;
        end else begin : g_res_wn
            logic [WIDTH-2:0] r_res;

            // Collect sum bits as they are produced
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_res <= '0;
                end else if (w_step) begin
                    r_res <= w_res_nxt[WIDTH-1:1];
                end
            end

            assign w_res_nxt = {w_s, r_res};
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand shift registers, bit counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_cnt    <= '0;
            sum      <= '0;
            carryout <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_a_sh <= r_a_sh >> 1;
                r_b_sh <= r_b_sh >> 1;
                r_cnt  <= r_cnt + 1'b1;
            end
            // Results are only touched at completion so they hold during RUN
            if (w_last) begin
                sum      <= w_res_nxt;
                carryout <= w_c_nxt;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                overflow <= w_c ^ w_c_nxt;
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder with a scoreboard queue.
//            Honours SERIAL_ADDER_OVERFLOW_EN for the overflow output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             overflow;
`endif

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .sum      (sum),
        .carryout (carryout),
        .busy     (busy),
        .done     (done)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        int               e0;
    } exp_t;

    exp_t q[$];

    logic [WIDTH-1:0] hold_sum = '0;
    logic             hold_co  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one add when the DUT is free; keep=1 leaves start asserted afterwards
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input bit keep);
        int          n;
        exp_t        e;
        logic [WIDTH:0] full;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
        a       = ia;
        b       = ib;
        carryin = ic;
        start   = 1'b1;
        full    = {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic};
        e.s     = full[WIDTH-1:0];
        e.co    = full[WIDTH];
        e.ov    = (ia[WIDTH-1] == ib[WIDTH-1]) && (full[WIDTH-1] != ia[WIDTH-1]);
        e.e0    = cyc + 1;
        q.push_back(e);
        if (!keep) begin
            @(negedge clk);
            start   = 1'b0;
            a       = WIDTH'($urandom);
            b       = WIDTH'($urandom);
            carryin = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: compare each done pulse against the scoreboard; check result hold while busy
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (done) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        check("sum",      32'(sum),      32'(e.s));
                        check("carryout", 32'(carryout), 32'(e.co));
                        check("latency",  32'(cyc - e.e0), 32'(WIDTH));
                        check("busy_at_done", 32'(busy), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        check("overflow", 32'(overflow), 32'(e.ov));
`endif
                        hold_sum = e.s;
                        hold_co  = e.co;
                    end
                end else if (busy) begin
                    check("sum_hold", 32'(sum),      32'(hold_sum));
                    check("co_hold",  32'(carryout), 32'(hold_co));
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        carryin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum",      32'(sum),      32'd0);
        check("rst_carryout", 32'(carryout), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("rst_overflow", 32'(overflow), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Directed sums, including full carry propagation
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);

        // start during RUN must be ignored
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a       = 8'h10;
        b       = 8'h10;
        carryin = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;

        // Reset mid-operation aborts without a done pulse
        issue(8'h55, 8'hAA, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        check("abort_sum",      32'(sum),      32'd0);
        check("abort_carryout", 32'(carryout), 32'd0);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_done",     32'(done),     32'd0);
        hold_sum = '0;
        hold_co  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue(8'h03, 8'h04, 1'b0, 1'b0);

        // Back-to-back with start held high
        issue(8'h01, 8'h02, 1'b0, 1'b1);
        issue(8'h10, 8'h20, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;

        // Signed overflow boundary cases
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'h80, 8'h80, 1'b0, 1'b0);

        // Random operands, sometimes back-to-back
        for (int i = 0; i < 40; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        start = 1'b0;

        // Drain outstanding results
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0 pending", q.size());
        end
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
